// File: rtl/muldiv_unit.sv
// Sequential unsigned multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide requests are rejected with err.
module muldiv_unit #(
  parameter int DW  = 12,
  parameter int RFW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [DW-1:0]  src1,
  input  logic [DW-1:0]  src2,
  input  logic [RFW-1:0] dest,
  output logic           busy,
  output logic           we,
  output logic [RFW-1:0] wr_address,
  output logic [DW-1:0]  wr_data,
  output logic           err
);

  // Handshake: a request is taken only when start=1 at an edge while in IDLE;
  // start is ignored otherwise. The result is delivered by a one-cycle we pulse.
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  count;
  logic [DW-1:0]  a_q, b_q, acc_q;
  logic [DW-1:0]  a_nxt, b_nxt, acc_nxt;
  logic [DW-1:0]  result;
  logic [RFW-1:0] dest_q;
  logic           accept;
  logic           reject;
  logic           last_step;

`ifdef MULDIV_DIV_EN
  logic        op_q;
  logic [DW:0] shifted;

  assign accept = (state == IDLE) && start;
  assign reject = 1'b0;
`else
  assign accept = (state == IDLE) && start && !op;
  assign reject = (state == IDLE) && start && op;
`endif

  assign last_step = (state == RUN) && (count == CW'(DW - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; register 0 is hardwired zero so it is never written
  always_comb begin
    busy = (state != IDLE);
    we   = (state == DONE) && (dest_q != '0);
  end

  // One iteration step. Multiply: acc accumulates, a shifts left, b shifts right.
  // Divide: acc holds the partial remainder, a shifts dividend bits out and quotient bits in.
  always_comb begin
    a_nxt   = a_q;
    b_nxt   = b_q;
    acc_nxt = acc_q;
`ifdef MULDIV_DIV_EN
    shifted = '0;
    if (op_q) begin
      shifted = {acc_q, a_q[DW-1]};
      if (shifted >= {1'b0, b_q}) begin
        acc_nxt = DW'(shifted - {1'b0, b_q});
        a_nxt   = {a_q[DW-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[DW-1:0];
        a_nxt   = {a_q[DW-2:0], 1'b0};
      end
    end else
`endif
    begin
      acc_nxt = b_q[0] ? acc_q + a_q : acc_q;
      a_nxt   = a_q << 1;
      b_nxt   = b_q >> 1;
    end
  end

`ifdef MULDIV_DIV_EN
  assign result = op_q ? a_nxt : acc_nxt;
`else
  assign result = acc_nxt;
`endif

  // Datapath registers and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      dest_q     <= '0;
      wr_address <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_q       <= 1'b0;
`endif
    end else begin
      err <= reject;
      if (accept) begin
        a_q    <= src1;
        b_q    <= src2;
        acc_q  <= '0;
        count  <= '0;
        dest_q <= dest;
`ifdef MULDIV_DIV_EN
        op_q   <= op;
`endif
      end else if (state == RUN) begin
        a_q   <= a_nxt;
        b_q   <= b_nxt;
        acc_q <= acc_nxt;
        count <= count + 1'b1;
        if (last_step) begin
          wr_data    <= result;
          wr_address <= dest_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int DW  = 12;
  localparam int RFW = 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic           op;
  logic [DW-1:0]  src1;
  logic [DW-1:0]  src2;
  logic [RFW-1:0] dest;
  logic           busy;
  logic           we;
  logic [RFW-1:0] wr_address;
  logic [DW-1:0]  wr_data;
  logic           err;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  muldiv_unit #(.DW(DW), .RFW(RFW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .dest(dest), .busy(busy), .we(we), .wr_address(wr_address),
    .wr_data(wr_data), .err(err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition
  function automatic logic [DW-1:0] model(input logic o, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    int unsigned p;
    if (!o) begin
      p = int'(a) * int'(b);
      return DW'(p % (1 << DW));
    end
    if (b == '0) return '1;
    return a / b;
  endfunction

  // Issue one operation and follow it cycle by cycle; inject_at > 0 pulses a spurious
  // start (random operands) before edge k+inject_at, which must be ignored.
  task automatic run_op(input logic o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RFW-1:0] d, input int inject_at);
    logic [DW-1:0] exp;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b; dest = d;
    @(posedge clk); #1;
    start = 1'b0; src1 = DW'($urandom); src2 = DW'($urandom);
    check("busy_at_start", busy, 1);
    check("we_at_start", we, 0);
    for (int j = 1; j <= DW + 1; j++) begin
      if (j == inject_at) begin
        @(negedge clk);
        start = 1'b1; op = 1'($urandom); src1 = DW'($urandom); src2 = DW'($urandom);
        dest = RFW'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("busy", busy, (j <= DW) ? 1 : 0);
      check("we", we, (j == DW && d != '0) ? 1 : 0);
      check("err_quiet", err, 0);
      if (j == DW) begin
        exp = exp_q.pop_front();
        check("wr_data", wr_data, exp);
        if (d != '0) check("wr_address", wr_address, d);
      end
      if (j == DW + 1) check("wr_data_hold", wr_data, exp);
    end
  endtask

  initial begin
    int we_seen;
    logic o;
    logic [DW-1:0] a, b;
    rst = 1'b1; start = 1'b0; op = 1'b0; src1 = '0; src2 = '0; dest = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_we", we, 0);
    check("rst_err", err, 0);
    check("rst_wr_address", wr_address, 0);
    check("rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 12'd5, 12'd7, 2'd1, 0);
    run_op(1'b0, 12'hFFF, 12'hFFF, 2'd2, 0);
    run_op(1'b0, 12'd9, 12'd3, 2'd1, 4);        // spurious start at edge 4
    run_op(1'b0, 12'd11, 12'd13, 2'd3, DW + 1); // start in DONE cycle, next one accepted
    run_op(1'b0, 12'd17, 12'd19, 2'd0, 0);      // dest 0: no write
    run_op(1'b0, 12'h800, 12'd2, 2'd2, 0);      // overflow to zero
`ifdef MULDIV_DIV_EN
    run_op(1'b1, 12'd100, 12'd7, 2'd3, 0);
    run_op(1'b1, 12'h123, 12'd0, 2'd3, 0);
    run_op(1'b1, 12'hFFF, 12'd1, 2'd1, 0);
    run_op(1'b1, 12'd5, 12'd6, 2'd2, 0);
`else
    @(negedge clk);
    start = 1'b1; op = 1'b1; src1 = 12'd100; src2 = 12'd7; dest = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("div_rej_err", err, 1);
    check("div_rej_busy", busy, 0);
    check("div_rej_we", we, 0);
    @(posedge clk); #1;
    check("div_rej_err_end", err, 0);
    check("div_rej_busy_end", busy, 0);
    check("div_rej_we_end", we, 0);
`endif

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
`ifdef MULDIV_DIV_EN
      o = 1'($urandom_range(0, 1));
`else
      o = 1'b0;
`endif
      a = DW'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      run_op(o, a, b, RFW'($urandom),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW + 1) : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of a run aborts it with no write
    @(negedge clk);
    start = 1'b1; op = 1'b0; src1 = 12'd21; src2 = 12'd3; dest = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_we", we, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_wr_address", wr_address, 0);
    @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    for (int j = 0; j < 2 * DW; j++) begin
      @(posedge clk); #1;
      if (we) we_seen++;
      if (busy) we_seen++;
    end
    check("abort_no_activity", we_seen, 0);

    // Unit works again after the abort
    run_op(1'b0, 12'd5, 12'd7, 2'd1, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
